// File: rtl/mux_scan_sequencer.sv
// Scans a 4:1 mux input by input via its select lines and rebuilds {in3..in0}.
// Snapshots are published on a valid/ready handshake; optional settle window.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   start              request one scan (sampled in IDLE only)
//   mux_out            multiplexer output fed back for sampling
//   address0/address1  registered multiplexer select lines
//   busy               FSM is not in IDLE
//   snap_valid/ready   snapshot handshake; snapshot stable while valid
//   snapshot           bit k = mux_out sampled with address k
//   scan_count         published snapshots, mod 256
// Build option: define MUX_SCAN_SETTLE_EN to insert SETTLE_CYCLES wait cycles
// before each sample; without it each bit takes a single SAMPLE cycle.
module mux_scan_sequencer #(
  parameter int SETTLE_CYCLES = 3,
  parameter bit CONTINUOUS    = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       mux_out,
  output logic       address0,
  output logic       address1,
  output logic       busy,
  output logic       snap_valid,
  input  logic       snap_ready,
  output logic [3:0] snapshot,
  output logic [7:0] scan_count
);

  if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 15) begin : g_bad_settle
    $error("SETTLE_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

`ifdef MUX_SCAN_SETTLE_EN
  localparam state_t FIRST = SETTLE;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
  logic [3:0] cnt;
`else
  localparam state_t FIRST = SAMPLE;
`endif

  state_t     state;
  logic [1:0] idx;
  logic [3:0] shadow;
  logic       pub;
  logic [3:0] pub_data;

  // Publish from the last SAMPLE (forwarding the live bit) or from HOLD.
  always_comb begin
    pub      = 1'b0;
    pub_data = shadow;
    if (state == SAMPLE && idx == 2'd3 &&
        (!snap_valid || snap_ready)) begin
      pub      = 1'b1;
      pub_data = {mux_out, shadow[2:0]};
    end else if (state == HOLD && snap_ready) begin
      pub = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= 2'd0;
      shadow     <= 4'd0;
      address0   <= 1'b0;
      address1   <= 1'b0;
      busy       <= 1'b0;
      snap_valid <= 1'b0;
      snapshot   <= 4'd0;
      scan_count <= 8'd0;
`ifdef MUX_SCAN_SETTLE_EN
      cnt        <= 4'd0;
`endif
    end else begin
      if (snap_valid && snap_ready) snap_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start || CONTINUOUS) begin
            state                <= FIRST;
            busy                 <= 1'b1;
            idx                  <= 2'd0;
            {address1, address0} <= 2'd0;
`ifdef MUX_SCAN_SETTLE_EN
            cnt                  <= 4'd0;
`endif
          end
        end
`ifdef MUX_SCAN_SETTLE_EN
        SETTLE: begin
          if (cnt == SETTLE_LAST) state <= SAMPLE;
          else cnt <= cnt + 4'd1;
        end
`endif
        SAMPLE: begin
          shadow[idx] <= mux_out;
          if (idx != 2'd3) begin
            idx                  <= idx + 2'd1;
            {address1, address0} <= idx + 2'd1;
            state                <= FIRST;
`ifdef MUX_SCAN_SETTLE_EN
            cnt                  <= 4'd0;
`endif
          end else if (!pub) begin
            state <= HOLD;
          end
        end
        HOLD: ;
        default: state <= IDLE;
      endcase
      // Publish overrides the case transitions above; a same-edge accept
      // leaves snap_valid set with the new data.
      if (pub) begin
        snapshot             <= pub_data;
        snap_valid           <= 1'b1;
        scan_count           <= scan_count + 8'd1;
        idx                  <= 2'd0;
        {address1, address0} <= 2'd0;
        state                <= CONTINUOUS ? FIRST : IDLE;
        busy                 <= CONTINUOUS;
`ifdef MUX_SCAN_SETTLE_EN
        cnt                  <= 4'd0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Self-checking bench for mux_scan_sequencer with a scoreboard of snapshots.
// Uses a zero-delay behavioural 4:1 mux; latency follows MUX_SCAN_SETTLE_EN.
module tb_mux_scan_sequencer;

  localparam int S = 3;
`ifdef MUX_SCAN_SETTLE_EN
  localparam int P = S + 1;
`else
  localparam int P = 1;
`endif

  logic       clk = 1'b0;
  logic       rst0, start0, sr0;
  logic       a0_0, a1_0, busy0, sv0, mo0;
  logic [3:0] snap0, in0;
  logic [7:0] cnt0;

  logic       rst1, start1, sr1;
  logic       a0_1, a1_1, busy1, sv1, mo1;
  logic [3:0] snap1, in1;
  logic [7:0] cnt1;

  logic [3:0] q[$];
  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign mo0 = in0[{a1_0, a0_0}];
  assign mo1 = in1[{a1_1, a0_1}];

  mux_scan_sequencer #(.SETTLE_CYCLES(S), .CONTINUOUS(1'b0)) u0 (
    .clk(clk), .reset(rst0), .start(start0), .mux_out(mo0),
    .address0(a0_0), .address1(a1_0), .busy(busy0),
    .snap_valid(sv0), .snap_ready(sr0), .snapshot(snap0),
    .scan_count(cnt0)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(S), .CONTINUOUS(1'b1)) u1 (
    .clk(clk), .reset(rst1), .start(start1), .mux_out(mo1),
    .address0(a0_1), .address1(a1_1), .busy(busy1),
    .snap_valid(sv1), .snap_ready(sr1), .snapshot(snap1),
    .scan_count(cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Handshake fires on the coming edge: compare against the scoreboard.
  always @(negedge clk) begin
    if (!rst0 && sv0 && sr0) begin
      chk("sb_depth", 32'(q.size() > 0), 1);
      if (q.size() > 0) chk("sb_snap", 32'(snap0), 32'(q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic drop;
    rst0 = 1'b1; start0 = 1'b0; sr0 = 1'b0; in0 = 4'd0;
    rst1 = 1'b1; start1 = 1'b0; sr1 = 1'b1; in1 = 4'd0;
    repeat (3) step();
    chk("rst_addr", 32'({a1_0, a0_0}), 0);
    chk("rst_busy", 32'(busy0), 0);
    chk("rst_valid", 32'(sv0), 0);
    chk("rst_snap", 32'(snap0), 0);
    chk("rst_cnt", 32'(cnt0), 0);
    rst0 = 1'b0;
    step();

    // Basic scan with address sequence and latency
    in0 = 4'b1010; sr0 = 1'b1; start0 = 1'b1;
    q.push_back(4'b1010);
    step();
    start0 = 1'b0;
    for (int k = 0; k < 4 * P; k++) begin
      chk("seq", 32'({sv0, busy0, a1_0, a0_0}), 32'(4 + k / P));
      step();
    end
    chk("lat_valid", 32'(sv0), 1);
    chk("lat_snap", 32'(snap0), 32'(4'b1010));
    chk("cnt1", 32'(cnt0), 1);
    chk("idle_busy", 32'({busy0, a1_0, a0_0}), 0);
    step();
    chk("drained", 32'(sv0), 0);

    // Back-pressure: second scan waits in HOLD
    sr0 = 1'b0; in0 = 4'b0101; start0 = 1'b1;
    q.push_back(4'b0101);
    step();
    start0 = 1'b0;
    repeat (4 * P) step();
    chk("bp_valid", 32'(sv0), 1);
    in0 = 4'b1100; start0 = 1'b1;
    q.push_back(4'b1100);
    step();
    start0 = 1'b0;
    repeat (4 * P + 3) step();
    chk("hold_busy_addr", 32'({busy0, a1_0, a0_0}), 7);
    chk("hold_snap", 32'(snap0), 32'(4'b0101));
    chk("hold_cnt", 32'(cnt0), 2);
    sr0 = 1'b1;
    step();
    sr0 = 1'b0;
    chk("swap_snap", 32'(snap0), 32'(4'b1100));
    chk("swap_valid", 32'(sv0), 1);
    chk("swap_cnt", 32'(cnt0), 3);
    chk("swap_idle", 32'(busy0), 0);
    sr0 = 1'b1;
    step();
    chk("swap_drained", 32'(sv0), 0);

    // start while busy is ignored
    in0 = 4'b0110; start0 = 1'b1;
    q.push_back(4'b0110);
    step();
    start0 = 1'b0;
    repeat (P) step();
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (12 * P) step();
    chk("ign_cnt", 32'(cnt0), 4);
    chk("ign_snap", 32'(snap0), 32'(4'b0110));
    chk("ign_idle", 32'({sv0, busy0}), 0);

    // Reset in the middle of a scan
    in0 = 4'b1111; sr0 = 1'b0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    repeat (6) step();
    rst0 = 1'b1;
    step();
    chk("mrst_addr", 32'({a1_0, a0_0}), 0);
    chk("mrst_busy", 32'(busy0), 0);
    chk("mrst_valid", 32'(sv0), 0);
    chk("mrst_snap", 32'(snap0), 0);
    chk("mrst_cnt", 32'(cnt0), 0);
    rst0 = 1'b0;
    repeat (4 * P + 4) step();
    chk("mrst_quiet", 32'({sv0, busy0}), 0);
    chk("mrst_cnt2", 32'(cnt0), 0);

    // Continuous mode: 256 scans wrap the counter
    in1 = 4'b1001; rst1 = 1'b0;
    step();
    chk("cont_busy", 32'(busy1), 1);
    drop = 1'b0;
    for (int n = 1; n <= 256; n++) begin
      repeat (4 * P) begin
        step();
        if (!busy1) drop = 1'b1;
      end
      if (n == 1) chk("cont_snap", 32'(snap1), 32'(4'b1001));
      if (n == 255) chk("cont_cnt255", 32'(cnt1), 255);
    end
    chk("cont_wrap", 32'(cnt1), 0);
    chk("cont_nodrop", 32'(drop), 0);
    chk("cont_valid", 32'(sv1), 1);

    chk("sb_empty", 32'(q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mux_scan_sequencer.md
# mux_scan_sequencer

Drives the two select lines of the structural 4:1 multiplexer and reads its single output back, one input at a time, to rebuild a 4-bit snapshot {in3,in2,in1,in0}. It sits directly upstream of the multiplexer for the select lines (`address0`, `address1`) and directly downstream of it for `out`. A settle window allows the multiplexer's gate delays (NOT/AND/AND/OR/OR chain, #5 each) to resolve before each sample. Completed snapshots are handed to the consumer over a valid/ready handshake.

## Interface
- SETTLE_CYCLES, 3: wait cycles after each select change before sampling; legal 1..15.
- CONTINUOUS, 0: 1 restarts a scan automatically after each publish; 0 waits for `start`.
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  input  1  request one scan; sampled only in IDLE.
- mux_out  input  1  multiplexer `out`.
- address0  output  1  multiplexer select bit 0, registered.
- address1  output  1  multiplexer select bit 1, registered.
- busy  output  1  high whenever state is not IDLE.
- snap_valid  output  1  snapshot holds an unconsumed result.
- snap_ready  input  1  consumer accepts the snapshot when high with `snap_valid`.
- snapshot  output  4  bit k = `mux_out` sampled with address = k.
- scan_count  output  8  number of published snapshots, mod 256.

## Operation
- States: IDLE, SETTLE, SAMPLE, HOLD.
- IDLE: address = 00. `start` (or CONTINUOUS=1) -> SETTLE, idx = 0, settle counter = 0.
- SETTLE: {address1,address0} = idx. Counter runs 0..SETTLE_CYCLES-1, then -> SAMPLE.
- SAMPLE: on exit edge, shadow[idx] <= `mux_out`.
  - idx < 3: idx+1, counter cleared, address updated on the same edge, -> SETTLE.
  - idx = 3 and (`snap_valid`=0 or `snap_ready`=1): `snapshot` <= {mux_out, shadow[2:0]}, `snap_valid` <= 1, `scan_count`+1, -> IDLE (-> SETTLE with idx 0 if CONTINUOUS=1).
  - idx = 3 and `snap_valid`=1 and `snap_ready`=0: -> HOLD.
- HOLD: address stays 11, shadow frozen. Publishes the shadow as above on the first cycle with `snap_ready`=1.
- Handshake: `snapshot` stable while `snap_valid`=1. `snap_ready` with `snap_valid` and no simultaneous publish clears `snap_valid` next edge. Accept and publish on the same edge keep `snap_valid`=1 with the new data.
- `start` while busy is ignored. It is not queued.
- `scan_count` wraps 255 -> 0.

## Timing
- Reset values: address0=0, address1=0, busy=0, snap_valid=0, snapshot=0000, scan_count=0, state IDLE, idx=0.
- Reset mid-scan or mid-HOLD discards the partial shadow and any pending snapshot. Outputs take reset values on the next edge.
- Per bit: SETTLE_CYCLES + 1 cycles. `snap_valid` rises 4*(SETTLE_CYCLES+1) edges after the edge that accepts `start`. Default: 16.
- Select lines change only on SAMPLE exit edges and on IDLE entry. They never change during SETTLE.
- HOLD adds one cycle per stalled cycle. No sample is lost.

## Configuration
- MUX_SCAN_SETTLE_EN
  - Defined: SETTLE state and counter are present, as described above.
  - Undefined: SETTLE is removed and SETTLE_CYCLES is ignored. Each bit uses one SAMPLE cycle, and `snap_valid` rises 4 edges after `start` is accepted. Use this only with a zero-delay multiplexer model.

## Test plan
- After reset, inputs 1010, `start` pulse, `snap_ready`=1 -> address sequence 00,01,10,11 with each value held 4 cycles; `snap_valid` at edge 16; `snapshot`=1010; `scan_count`=1.
- `snap_ready`=0, two back-to-back scans (0101 then 1100) -> FSM holds in HOLD with address 11; `snapshot` stays 0101. Raising `snap_ready` for one cycle -> `snapshot`=1100 and `snap_valid` stays 1.
- `start` pulsed while busy -> ignored; exactly one snapshot is produced.
- `reset` asserted at cycle 7 of a scan -> all outputs take reset values next edge; no `snap_valid`; `scan_count`=0.
- CONTINUOUS=1, `snap_ready`=1, 256 scans -> `scan_count` wraps to 0; `busy` never drops.
- MUX_SCAN_SETTLE_EN undefined, input 0110 -> `snapshot`=0110 and `snap_valid` at edge 4.
